// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// interrupt vector width and a helper that masks off unimplemented lanes.
package irq_ctrl_pkg;

  localparam int IRQ_VEC_W = 16;

  typedef enum logic [1:0] {
    IRQ_REG_MASK   = 2'd0,
    IRQ_REG_MODE   = 2'd1,
    IRQ_REG_POL    = 2'd2,
    IRQ_REG_SWTRIG = 2'd3
  } irq_reg_e;

  // Bits at or above n are forced to zero in every 16-bit field.
  function automatic logic [IRQ_VEC_W-1:0] lane_mask(input int n);
    logic [IRQ_VEC_W-1:0] m;
    m = '0;
    for (int i = 0; i < IRQ_VEC_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Configuration bus and interrupt pulse vector between the control-register
// write path (master) and the interrupt controller (slave).
interface irq_ctrl_if;
  import irq_ctrl_pkg::*;

  logic                 cfg_wen;
  logic [1:0]           cfg_addr;
  logic [31:0]          cfg_wdata;
  logic [31:0]          cfg_rdata;
  logic [IRQ_VEC_W-1:0] interrupts;

  modport master (output cfg_wen, cfg_addr, cfg_wdata,
                  input  cfg_rdata, interrupts);
  modport slave  (input  cfg_wen, cfg_addr, cfg_wdata,
                  output cfg_rdata, interrupts);
endinterface

// File: rtl/irq_sync.sv
// Multi-stage flop synchronizer for the asynchronous device interrupt lines.
module irq_sync #(
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] d,
  output logic [NUM_IRQ-1:0] q
);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller: synchronizes device lines, applies polarity,
// edge/level mode and mask, and drives a registered one-cycle pulse vector.
// Optional per-line pulse holdoff is enabled by defining IRQ_HOLDOFF_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ        = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_ctrl_if.slave          bus
);

  localparam logic [IRQ_VEC_W-1:0] LANES = lane_mask(NUM_IRQ);

  logic [NUM_IRQ-1:0]   sync_out;
  logic [IRQ_VEC_W-1:0] s, ev, hw, fire, swtrig;
  logic [IRQ_VEC_W-1:0] mask_q, mask_d, mode_q, mode_d, pol_q, pol_d;
  logic [IRQ_VEC_W-1:0] prev_q, prev_d, irq_q, irq_d;
  logic                 wr;
  logic                 unused_wdata;

  irq_sync #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_in),
    .q     (sync_out)
  );

  assign s            = (IRQ_VEC_W'(sync_out) ^ pol_q) & LANES;
  assign unused_wdata = ^bus.cfg_wdata[31:16];

`ifdef IRQ_HOLDOFF_EN
  localparam int CW = $clog2(HOLDOFF_CYCLES + 1);
  logic [IRQ_VEC_W-1:0][CW-1:0] cnt_q, cnt_d;
  logic [IRQ_VEC_W-1:0]         def_q, def_d;
`else
  localparam int unused_holdoff = HOLDOFF_CYCLES;
`endif

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    swtrig = '0;
    wr     = bus.cfg_wen && clk_en;
    if (wr) begin
      case (irq_reg_e'(bus.cfg_addr))
        IRQ_REG_MASK:   mask_d = bus.cfg_wdata[15:0] & LANES;
        IRQ_REG_MODE:   mode_d = bus.cfg_wdata[15:0] & LANES;
        IRQ_REG_POL:    pol_d  = bus.cfg_wdata[15:0] & LANES;
        IRQ_REG_SWTRIG: swtrig = bus.cfg_wdata[15:0] & LANES;
        default:        swtrig = '0;
      endcase
    end

    // p tracks the post-polarity value, so a polarity flip looks like an edge.
    prev_d = s;
    ev     = (mode_q & s) | (~mode_q & s & ~prev_q);
    hw     = ev & mask_q;

`ifdef IRQ_HOLDOFF_EN
    cnt_d = cnt_q;
    def_d = def_q;
    fire  = '0;
    for (int i = 0; i < IRQ_VEC_W; i++) begin
      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
        if (hw[i]) def_d[i] = 1'b1;
      end else if (hw[i] || def_q[i]) begin
        fire[i]  = 1'b1;
        cnt_d[i] = CW'(HOLDOFF_CYCLES);
        def_d[i] = 1'b0;
      end
    end
`else
    fire = hw;
`endif

    irq_d = fire | swtrig;
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (irq_reg_e'(bus.cfg_addr))
      IRQ_REG_MASK:   bus.cfg_rdata[15:0] = mask_q;
      IRQ_REG_MODE:   bus.cfg_rdata[15:0] = mode_q;
      IRQ_REG_POL:    bus.cfg_rdata[15:0] = pol_q;
      IRQ_REG_SWTRIG: bus.cfg_rdata[15:0] = s;
      default:        bus.cfg_rdata       = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      prev_q <= '0;
      irq_q  <= '0;
`ifdef IRQ_HOLDOFF_EN
      cnt_q  <= '0;
      def_q  <= '0;
`endif
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      prev_q <= prev_d;
      irq_q  <= irq_d;
`ifdef IRQ_HOLDOFF_EN
      cnt_q  <= cnt_d;
      def_q  <= def_d;
`endif
    end
  end

  assign bus.interrupts = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized plus directed bench for irq_ctrl against a cycle-history
// reference model (optionally modelling holdoff when IRQ_HOLDOFF_EN is set).
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NUM_IRQ        = 16;
  localparam int SYNC_STAGES    = 2;
  localparam int HOLDOFF_CYCLES = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clk_en = 1'b0;
  logic [15:0] irq_in = '0;

  irq_ctrl_if bus();

  irq_ctrl #(
    .NUM_IRQ        (NUM_IRQ),
    .SYNC_STAGES    (SYNC_STAGES),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .irq_in (irq_in),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // stimulus copies the model reads
  logic        st_wen;
  logic [1:0]  st_addr;
  logic [31:0] st_wdata;
  logic        st_en;

  // reference model: registers plus history of raw line values per edge
  logic [15:0] m_mask, m_mode, m_pol, m_prev, exp_int;
  logic [15:0] hist[$];
  int          cycle;
`ifdef IRQ_HOLDOFF_EN
  int          last_fire[16];
  bit          pend[16];
`endif

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h expected=%h cycle=%0d", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [15:0] synced_line();
    return hist[hist.size() - SYNC_STAGES] ^ m_pol;
  endfunction

  function automatic logic [31:0] exp_rdata();
    case (st_addr)
      2'd0:    return {16'h0, m_mask};
      2'd1:    return {16'h0, m_mode};
      2'd2:    return {16'h0, m_pol};
      default: return {16'h0, synced_line()};
    endcase
  endfunction

  task automatic model_reset();
    m_mask = '0; m_mode = '0; m_pol = '0; m_prev = '0; exp_int = '0;
    hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(16'h0);
    cycle = 0;
`ifdef IRQ_HOLDOFF_EN
    for (int i = 0; i < 16; i++) begin
      last_fire[i] = -1000;
      pend[i] = 1'b0;
    end
`endif
  endtask

  task automatic model_edge();
    logic [15:0] s, fire, sw;
    s    = synced_line();
    fire = '0;
    for (int i = 0; i < 16; i++) begin
      bit event_i;
      event_i = m_mode[i] ? s[i] : (s[i] && !m_prev[i]);
      event_i = event_i && m_mask[i];
`ifdef IRQ_HOLDOFF_EN
      if (event_i || pend[i]) begin
        if (cycle - last_fire[i] >= HOLDOFF_CYCLES + 1) begin
          fire[i] = 1'b1;
          last_fire[i] = cycle;
          pend[i] = 1'b0;
        end else begin
          pend[i] = 1'b1;
        end
      end
`else
      fire[i] = event_i;
`endif
    end
    sw = (st_wen && st_en && st_addr == 2'd3) ? st_wdata[15:0] : 16'h0;
    exp_int = fire | sw;
    m_prev  = s;
    if (st_wen && st_en) begin
      case (st_addr)
        2'd0: m_mask = st_wdata[15:0];
        2'd1: m_mode = st_wdata[15:0];
        2'd2: m_pol  = st_wdata[15:0];
        default: ;
      endcase
    end
    hist.push_back(irq_in);
    void'(hist.pop_front());
    cycle++;
  endtask

  task automatic applyStimulus(input logic wen, input logic [1:0] addr,
                               input logic [31:0] wdata, input logic en,
                               input logic [15:0] irq);
    st_wen = wen; st_addr = addr; st_wdata = wdata; st_en = en;
    bus.cfg_wen = wen; bus.cfg_addr = addr; bus.cfg_wdata = wdata;
    clk_en = en; irq_in = irq;
  endtask

  // one clock: model follows the edge, outputs checked on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    checkOutput("interrupts", {16'h0, bus.interrupts}, {16'h0, exp_int});
    checkOutput("cfg_rdata", bus.cfg_rdata, exp_rdata());
  endtask

  task automatic cyc(input logic wen, input logic [1:0] addr, input logic [31:0] wdata,
                     input logic en, input logic [15:0] irq);
    applyStimulus(wen, addr, wdata, en, irq);
    tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_interrupts", {16'h0, bus.interrupts}, 32'h0);
    checkOutput("rst_rdata", bus.cfg_rdata, exp_rdata());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int cnt;

  initial begin
    model_reset();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 16'h0);
    @(negedge clk);
    doReset();

    // edge mode: a held line pulses once
    cyc(1'b1, 2'd0, 32'h0001, 1'b1, 16'h0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 2'd0, 32'h0, 1'b1, 16'h0001);
      cnt += int'(bus.interrupts[0]);
    end
    checkOutput("edge_once", cnt, 1);

    // level mode: 5 held cycles give 5 pulse cycles
    cyc(1'b1, 2'd1, 32'h0004, 1'b1, 16'h0);
    cyc(1'b1, 2'd0, 32'h0004, 1'b1, 16'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 2'd1, 32'h0, 1'b1, (i < 5) ? 16'h0004 : 16'h0);
      cnt += int'(bus.interrupts[2]);
    end
    checkOutput("level_len", cnt, 5);

    // masked line drops events and does not replay on unmask
    cyc(1'b1, 2'd0, 32'h0, 1'b1, 16'h0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 2'd0, 32'h0, 1'b1, (i % 2 == 0) ? 16'h0020 : 16'h0);
      cnt += int'(bus.interrupts[5]);
    end
    cyc(1'b1, 2'd0, 32'h0020, 1'b1, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'd0, 32'h0, 1'b1, 16'h0);
      cnt += int'(bus.interrupts[5]);
    end
    checkOutput("masked_no_replay", cnt, 0);

    // software trigger, then the same write with clk_en low
    cyc(1'b1, 2'd0, 32'h0, 1'b1, 16'h0);
    cyc(1'b1, 2'd3, 32'h8001, 1'b1, 16'h0);
    checkOutput("swtrig_pulse", {16'h0, bus.interrupts}, 32'h8001);
    cyc(1'b0, 2'd0, 32'h0, 1'b1, 16'h0);
    checkOutput("swtrig_clear", {16'h0, bus.interrupts}, 32'h0);
    cyc(1'b1, 2'd3, 32'h8001, 1'b0, 16'h0);
    checkOutput("swtrig_gated", {16'h0, bus.interrupts}, 32'h0);

    // polarity flip on a static line yields one edge; RAW reads inverted value
    doReset();
    cyc(1'b1, 2'd0, 32'h0002, 1'b1, 16'h0);
    cyc(1'b1, 2'd2, 32'h0002, 1'b1, 16'h0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'd3, 32'h0, 1'b1, 16'h0);
      cnt += int'(bus.interrupts[1]);
    end
    checkOutput("pol_once", cnt, 1);
    checkOutput("raw_read", bus.cfg_rdata, 32'h0002);

    // reset while a pulse is visible clears it at once
    cyc(1'b1, 2'd3, 32'h00F0, 1'b1, 16'h0);
    doReset();

`ifdef IRQ_HOLDOFF_EN
    // three close edges on line 3: one immediate pulse, one deferred
    cyc(1'b1, 2'd0, 32'h0008, 1'b1, 16'h0);
    cnt = 0;
    for (int i = 0; i < 2 * HOLDOFF_CYCLES + 8; i++) begin
      cyc(1'b0, 2'd0, 32'h0, 1'b1, (i == 0 || i == 2 || i == 4) ? 16'h0008 : 16'h0);
      cnt += int'(bus.interrupts[3]);
    end
    checkOutput("holdoff_pulses", cnt, 2);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] nirq;
      if ($urandom_range(0, 499) == 0) doReset();
      nirq = irq_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      cyc($urandom_range(0, 2) == 0, 2'($urandom), $urandom,
          $urandom_range(0, 3) != 0, nirq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
